// File: rtl/nrdiv_pkg.sv
// Shared types and helpers for the non-restoring divider.
package nrdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Width of a counter that must hold the value w itself.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/nrdiv_step.sv
// One combinational non-restoring iteration: shift {A,Q} left, then add or subtract M.
module nrdiv_step
    import nrdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 1024
) (
    input  logic [WIDTH:0]   a,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] m,
    input  logic             a_neg,
    output logic [WIDTH:0]   a_next,
    output logic             q_lsb
);

    logic [WIDTH:0] a_shift;
    logic [WIDTH:0] m_ext;

    assign a_shift = {a[WIDTH-1:0], q_msb};
    assign m_ext   = {1'b0, m};
    assign a_next  = a_neg ? (a_shift + m_ext) : (a_shift - m_ext);
    assign q_lsb   = ~a_next[WIDTH];

endmodule

// File: rtl/nonrestoring_div_param.sv
// Handshaked multi-cycle unsigned non-restoring divider, one quotient bit per cycle.
module nonrestoring_div_param
    import nrdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [WIDTH:0]     a;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   m;
    logic [CNT_W-1:0]   count;
    logic [WIDTH:0]     a_step;
    logic               q_lsb;
    logic [WIDTH:0]     a_fix;
    logic               divisor_zero;

    assign divisor_zero = (divisor == '0);
    // Final correction brings a negative partial remainder back into [0, M).
    assign a_fix        = a[WIDTH] ? (a + {1'b0, m}) : a;

    nrdiv_step #(.WIDTH(WIDTH)) u_step (
        .a      (a),
        .q_msb  (q[WIDTH-1]),
        .m      (m),
        .a_neg  (a[WIDTH]),
        .a_next (a_step),
        .q_lsb  (q_lsb)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = divisor_zero ? DONE : CALC;
            CALC: if (count == CNT_W'(1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a           <= '0;
            q           <= '0;
            m           <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q     <= dividend;
                        m     <= divisor;
                        a     <= '0;
                        count <= CNT_W'(WIDTH);
                        if (divisor_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    a     <= a_step;
                    q     <= {q[WIDTH-2:0], q_lsb};
                    count <= count - CNT_W'(1);
                end
                FIX: begin
                    a           <= a_fix;
                    quotient    <= q;
                    remainder   <= a_fix[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
